// File: rtl/d_latch.sv
// Level-sensitive D latch with asynchronous active-low clear, WIDTH bits wide.
// Define D_LATCH_STRUCTURAL_EN to build each bit from NAND/NOT gate primitives instead.
module d_latch #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             clr
);

`ifdef D_LATCH_STRUCTURAL_EN

  // Gated SR latch per bit. clr enters the set NAND and the q_n NAND,
  // forcing s_n=1 and q_n=1, which drives q to 0 regardless of clk and d.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    wire d_n;
    wire s_n;
    wire r_n;
    wire q_n;

    not  u_inv (d_n, d[i]);
    nand u_set (s_n, d[i], clk, clr);
    nand u_rst (r_n, d_n, clk);
    nand u_q   (q[i], s_n, q_n);
    nand u_qn  (q_n, r_n, q[i], clr);
  end

`else

  // NOTE: always_latch states the storage intent; q keeps its value when
  // neither branch assigns it (clr high, clk low), which is the hold phase.
  always_latch begin
    if (!clr) begin
      q <= '0;
    end else if (clk) begin
      q <= d;
    end
  end

`endif

endmodule

// File: tb/tb_d_latch.sv
// Self-checking bench for d_latch (WIDTH=8): free-running directed phases,
// a vector table, and randomized steps scored against a history-scan model.
`timescale 1ns/1ps
module tb_d_latch;

  localparam int W = 8;

  logic [W-1:0] d;
  logic         clr;
  logic         clk_gen;
  logic         clk_man;
  logic         free_run;
  wire          clk;
  wire  [W-1:0] q;

  int n_tests = 0;
  int n_fail  = 0;

  assign clk = free_run ? clk_gen : clk_man;

  d_latch #(.WIDTH(W)) dut (
    .q   (q),
    .d   (d),
    .clk (clk),
    .clr (clr)
  );

  initial begin
    clk_gen = 1'b1;
    forever #1 clk_gen = ~clk_gen;
  end

  typedef struct {
    logic         clr;
    logic         clk;
    logic [W-1:0] d;
    logic [W-1:0] exp_q;
  } vec_t;

  typedef struct {
    logic         clr;
    logic         clk;
    logic [W-1:0] d;
  } step_t;

  step_t hist[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: q=%h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic at(input realtime t);
    if (t > $realtime) #(t - $realtime);
  endtask

  // The latch output is the d of the most recent step that was transparent,
  // or zero if the most recent clr-low step came later.
  function automatic logic [W-1:0] model_q();
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (!hist[i].clr) return '0;
      if (hist[i].clk)  return hist[i].d;
    end
    return 'x;
  endfunction

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 8'hFF, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 8'hFF, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 8'hFF, 8'hFF};
    vecs[3]  = '{1'b1, 1'b1, 8'h0F, 8'h0F};
    vecs[4]  = '{1'b1, 1'b0, 8'h0F, 8'h0F};
    vecs[5]  = '{1'b1, 1'b0, 8'hF0, 8'h0F};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 8'h0F};
    vecs[7]  = '{1'b1, 1'b1, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, 1'b1, 8'h81, 8'h81};
    vecs[9]  = '{1'b1, 1'b0, 8'h81, 8'h81};
    vecs[10] = '{1'b0, 1'b0, 8'h81, 8'h00};
    vecs[11] = '{1'b1, 1'b0, 8'h7E, 8'h00};
    vecs[12] = '{1'b1, 1'b1, 8'h7E, 8'h7E};
    vecs[13] = '{1'b0, 1'b0, 8'h7E, 8'h00};
    vecs[14] = '{1'b1, 1'b0, 8'h7E, 8'h00};

    free_run = 1'b1;
    clk_man  = 1'b0;
    clr      = 1'b0;
    d        = 8'hFF;

    // clr low dominates through all clk phases, d all ones
    for (int i = 0; i < 10; i++) begin
      at(i + 0.5);
      check("clr_low_d1", q, 8'h00);
    end
    at(10.0);
    d = 8'h00;
    for (int i = 10; i < 20; i++) begin
      at(i + 0.5);
      check("clr_low_d0", q, 8'h00);
    end
    at(20.0);
    d = 8'hFF;
    for (int i = 20; i < 30; i++) begin
      at(i + 0.5);
      check("clr_low_d1b", q, 8'h00);
    end

    // transparency and hold while clk is low
    at(30.25); clr = 1'b1; d = 8'hFF;
    at(30.5);  check("transparent_first_high", q, 8'hFF);
    at(31.25); d = 8'h00;
    at(31.5);  check("hold_while_low", q, 8'hFF);
    at(32.5);  check("follow_next_high", q, 8'h00);

    // d=0 held for 20 ns, then d=1 in a low phase, then clr mid-high
    at(34.5);  check("d0_period_a", q, 8'h00);
    at(52.5);  check("d0_period_b", q, 8'h00);
    at(53.25); d = 8'hFF;
    at(53.5);  check("d1_ignored_low", q, 8'h00);
    at(54.5);  check("d1_at_high", q, 8'hFF);
    at(54.75); clr = 1'b0;
    at(54.85); check("clr_mid_high", q, 8'h00);

    // clr released in low phase: stays zero until clk rises
    at(55.25); clr = 1'b1;
    at(55.5);  check("release_low_holds0", q, 8'h00);
    at(56.5);  check("release_low_next_rise", q, 8'hFF);

    // clr released in high phase: follows d at once
    at(56.6);  clr = 1'b0; d = 8'h5A;
    at(56.7);  check("clr_pulse_high", q, 8'h00);
    at(56.8);  clr = 1'b1;
    at(56.9);  check("release_high_follows", q, 8'h5A);

    // multi-bit hold and clear
    at(58.25); d = 8'hA5;
    at(58.5);  check("w8_transparent", q, 8'hA5);
    at(59.25); d = 8'h3C;
    at(59.5);  check("w8_hold", q, 8'hA5);
    at(59.75); clr = 1'b0;
    at(59.9);  check("w8_clear", q, 8'h00);

    // switch to a manually driven gate while the free clock is low
    at(61.5);
    clk_man  = 1'b0;
    free_run = 1'b0;
    #1;

    foreach (vecs[i]) begin
      clr     = vecs[i].clr;
      clk_man = vecs[i].clk;
      d       = vecs[i].d;
      #1;
      check($sformatf("vec%0d", i), q, vecs[i].exp_q);
    end

    // randomized steps; d never changes together with a falling gate
    clr     = 1'b0;
    clk_man = 1'b0;
    d       = W'($urandom);
    #1;
    hist.push_back('{clr, clk_man, d});
    check("rand_init", q, model_q());
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 4))
        0: clk_man = ~clk_man;
        1, 2: d = W'($urandom);
        3: clr = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
        default: begin
          if (!clk_man) begin
            clk_man = 1'b1;
            d       = W'($urandom);
          end else begin
            clk_man = 1'b0;
          end
        end
      endcase
      #1;
      hist.push_back('{clr, clk_man, d});
      check($sformatf("rand%0d", n), q, model_q());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
